d_key_generator: RTL and testbench

//  Computes the RSA private exponent d = e^-1 mod phi from the verified e_key and phi

---
 rtl/d_key_generator.sv | 179 +++++++++++++++++
 tb/tb_d_key_generator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/d_key_generator.sv
// RSA private exponent d = e_key^-1 mod phi via iterative extended Euclid with a bit-serial
// restoring divider. Optional DKG_CYCLE_COUNT_EN adds a saturating busy-cycle counter port.
module d_key_generator #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] phi,
  input  logic [WIDTH-1:0] e_key,
  output logic             busy,
  output logic             valid,
  output logic             error,
  output logic [WIDTH-1:0] d_key
`ifdef DKG_CYCLE_COUNT_EN
  ,
  output logic [15:0]      cycles
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {StIdle, StDiv, StUpd, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r0_q, r0_d, r1_q, r1_d, rem_q, rem_d, phi_q, phi_d;
  logic [WIDTH:0]   t0_q, t0_d, t1_q, t1_d, acc_q, acc_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic             valid_q, valid_d, error_q, error_d;
  logic [WIDTH-1:0] dkey_q, dkey_d;

  logic [WIDTH:0]   rem_sh, rem_sub, acc_sh, t0_pos;
  logic             qbit;

  always_comb begin
    rem_sh  = {rem_q, r0_q[bit_q]};
    qbit    = (rem_sh >= {1'b0, r1_q});
    rem_sub = rem_sh - {1'b0, r1_q};
    // q*t1 accumulated by shift-add alongside the quotient bits, wrapping mod 2^(WIDTH+1)
    acc_sh  = {acc_q[WIDTH-1:0], 1'b0} + (qbit ? t1_q : '0);
    t0_pos  = t0_q + {1'b0, phi_q};
  end

  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    rem_d   = rem_q;
    phi_d   = phi_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    acc_d   = acc_q;
    bit_d   = bit_q;
    valid_d = valid_q;
    error_d = error_q;
    dkey_d  = dkey_q;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          r0_d    = phi;
          r1_d    = e_key;
          phi_d   = phi;
          t0_d    = '0;
          t1_d    = (WIDTH+1)'(1);
          rem_d   = '0;
          acc_d   = '0;
          bit_d   = CW'(WIDTH - 1);
          state_d = (e_key == '0) ? StFix : StDiv;
        end
      end
      StDiv: begin
        if (!en) begin
          state_d = StIdle;
        end else begin
          rem_d = qbit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          acc_d = acc_sh;
          if (bit_q == '0) state_d = StUpd;
          else             bit_d   = bit_q - 1'b1;
        end
      end
      StUpd: begin
        if (!en) begin
          state_d = StIdle;
        end else begin
          r0_d    = r1_q;
          r1_d    = rem_q;
          t0_d    = t1_q;
          t1_d    = t0_q - acc_q;
          rem_d   = '0;
          acc_d   = '0;
          bit_d   = CW'(WIDTH - 1);
          state_d = (rem_q != '0) ? StDiv : StFix;
        end
      end
      StFix: begin
        if (!en) begin
          state_d = StIdle;
        end else begin
          state_d = StDone;
          // phi<=1 has no invertible residue even when the gcd comes out as 1
          if (r0_q == WIDTH'(1) && phi_q > WIDTH'(1)) begin
            valid_d = 1'b1;
            dkey_d  = t0_q[WIDTH] ? t0_pos[WIDTH-1:0] : t0_q[WIDTH-1:0];
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (!en) begin
          state_d = StIdle;
          valid_d = 1'b0;
          error_d = 1'b0;
          dkey_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r0_q    <= '0;
      r1_q    <= '0;
      rem_q   <= '0;
      phi_q   <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      acc_q   <= '0;
      bit_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      dkey_q  <= '0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      rem_q   <= rem_d;
      phi_q   <= phi_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      error_q <= error_d;
      dkey_q  <= dkey_d;
    end
  end

  assign busy  = (state_q == StDiv) || (state_q == StUpd) || (state_q == StFix);
  assign valid = valid_q;
  assign error = error_q;
  assign d_key = dkey_q;

`ifdef DKG_CYCLE_COUNT_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q != StIdle && state_d == StIdle) begin
      cyc_d = '0;
    end else if (state_q == StIdle && state_d != StIdle) begin
      // the capture cycle counts toward the reported latency
      cyc_d = 16'd1;
    end else if (busy && cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_d_key_generator.sv
// Self-checking bench for d_key_generator: directed vector table, hand-written abort/reset
// sequences and random requests checked against a plain-arithmetic modular-inverse model.
module tb_d_key_generator;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] phi_in, e_in;
  logic         busy, valid, error;
  logic [W-1:0] d_key;
`ifdef DKG_CYCLE_COUNT_EN
  logic [15:0]  cycles;
`endif

  int checks = 0;
  int errors = 0;

  d_key_generator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .phi   (phi_in),
    .e_key (e_in),
    .busy  (busy),
    .valid (valid),
    .error (error),
    .d_key (d_key)
`ifdef DKG_CYCLE_COUNT_EN
    ,
    .cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] p;
    logic [W-1:0] e;
    logic         ev;
    logic         ee;
    logic [W-1:0] ed;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: textbook extended Euclid on signed 64-bit integers.
  function automatic void ref_inv(input longint p, input longint e, output bit ok,
                                  output longint d);
    longint a, b, ta, tb, q, tmp;
    a = p; b = e; ta = 0; tb = 1;
    while (b != 0) begin
      q = a / b;
      tmp = a - q * b; a = b; b = tmp;
      tmp = ta - q * tb; ta = tb; tb = tmp;
    end
    ok = (a == 1) && (p > 1);
    d  = ok ? (((ta % p) + p) % p) : 0;
  endfunction

  task automatic do_req(input logic [W-1:0] p, input logic [W-1:0] e, output logic ov,
                        output logic oe, output logic [W-1:0] od, output logic ob,
                        output int lat);
    phi_in = p;
    e_in   = e;
    en     = 1'b1;
    lat    = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(valid || error) && lat < 3000);
    ov = valid; oe = error; od = d_key; ob = busy;
    if (lat >= 3000) begin
      errors++;
      checks++;
      $display("FAIL timeout actual=%0d expected=<3000 phi=%0h e=%0h", lat, p, e);
    end
  endtask

  task automatic release_en();
    en = 1'b0;
    @(negedge clk);
    check("idle_outputs", {busy, valid, error, d_key}, '0);
  endtask

  task automatic run_and_check(input string name, input logic [W-1:0] p, input logic [W-1:0] e);
    logic ov, oe, ob;
    logic [W-1:0] od;
    int lat;
    bit ok;
    longint d;
    longint unsigned prod;
    ref_inv(longint'(p), longint'(e), ok, d);
    do_req(p, e, ov, oe, od, ob, lat);
    check({name, "_valid"}, ov, ok);
    check({name, "_error"}, oe, !ok);
    check({name, "_dkey"}, od, ok ? d[W-1:0] : '0);
    check({name, "_busy"}, ob, 1'b0);
    if (ok) begin
      prod = (longint'(e) * longint'(od)) % longint'(p);
      check({name, "_ed_mod"}, prod, 1);
    end
    release_en();
  endtask

  initial begin
    vec_t vecs[$];
    logic ov, oe, ob;
    logic [W-1:0] od;
    int lat;
    logic seen;
    logic [W-1:0] rp, re;

    vecs.push_back('{p: 3120, e: 17, ev: 1, ee: 0, ed: 2753});
    vecs.push_back('{p: 40,   e: 3,  ev: 1, ee: 0, ed: 27});
    vecs.push_back('{p: 3120, e: 15, ev: 0, ee: 1, ed: 0});
    vecs.push_back('{p: 3120, e: 0,  ev: 0, ee: 1, ed: 0});
    vecs.push_back('{p: 3120, e: 1,  ev: 1, ee: 0, ed: 1});
    vecs.push_back('{p: 1,    e: 1,  ev: 0, ee: 1, ed: 0});
    vecs.push_back('{p: 0,    e: 5,  ev: 0, ee: 1, ed: 0});
    vecs.push_back('{p: 0,    e: 1,  ev: 0, ee: 1, ed: 0});
    vecs.push_back('{p: 40,   e: 43, ev: 1, ee: 0, ed: 27});
    vecs.push_back('{p: 7,    e: 3,  ev: 1, ee: 0, ed: 5});

    rst_n = 1'b0; en = 1'b0; phi_in = '0; e_in = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, valid, error, d_key}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_req(vecs[i].p, vecs[i].e, ov, oe, od, ob, lat);
      check($sformatf("vec%0d_valid", i), ov, vecs[i].ev);
      check($sformatf("vec%0d_error", i), oe, vecs[i].ee);
      check($sformatf("vec%0d_dkey", i), od, vecs[i].ed);
      check($sformatf("vec%0d_busy", i), ob, 1'b0);
      check($sformatf("vec%0d_exclusive", i), ov & oe, 1'b0);
`ifdef DKG_CYCLE_COUNT_EN
      if (i == 0) check("cycles_3120_17", cycles, 16'd134);
`endif
      if (i == 0) begin
        repeat (3) @(negedge clk);
        check("hold_valid", {valid, error, d_key}, {1'b1, 1'b0, W'(2753)});
      end
      release_en();
    end

    run_and_check("big", 32'hFFFF_FFFE, 32'h0001_0001);

    // Reset pulse in the middle of the division.
    phi_in = 3120; e_in = 17; en = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_div_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("after_reset", {busy, valid, error, d_key}, '0);
    rst_n = 1'b1; en = 1'b0;
    @(negedge clk);
    run_and_check("post_reset", 3120, 17);

    // en dropped mid-division aborts with no result.
    phi_in = 3120; e_in = 17; en = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= valid | error;
    end
    check("abort_no_pulse", seen, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rp = (i % 3 == 0) ? W'($urandom_range(1, 1000)) : W'($urandom);
      re = (i % 2 == 0) ? W'($urandom_range(0, 70000)) : W'($urandom);
      run_and_check($sformatf("rnd%0d", i), rp, re);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
